dds_voice_bank: RTL and testbench

- Parametrised successor to the fixed three-voice DDS top level.
- NV voices share one phase adder and one waveform shaper, time-multiplexed round-robin, one voice per clock.
- Per-voice tuning word, waveform and phase clear are loaded through a valid/ready config port.
- Voice samples are summed into one mix sample, emitted once per NV-cycle frame with a one-cycle strobe. The block replaces the per-voice instances and the output mux.

---
 rtl/dds_pkg.sv | 32 +++
 rtl/dds_wave_shaper.sv | 29 ++
 rtl/dds_voice_bank.sv | 160 ++++++++++++++++
 tb/tb_dds_voice_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dds_pkg : shared types and elaboration helpers for the DDS voice bank |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'd0,
        WAVE_SQR  = 2'd1,
        WAVE_TRI  = 2'd2,
        WAVE_MUTE = 2'd3
    } wave_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int nv, input int n, input int m);
        return (nv >= 2) && (nv <= 16) && (m >= 2) && (m <= n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_wave_shaper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dds_wave_shaper : maps the top M phase bits to an unsigned sample     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int M = 12
) (
    input  wave_e          wave_i,
    input  logic [M-1:0]   phase_i,
    output logic [M-1:0]   sample_o
);

    always_comb begin
        sample_o = '0;
        case (wave_i)
            WAVE_SAW: sample_o = phase_i;
            WAVE_SQR: sample_o = {M{phase_i[M-1]}};
            // Triangle folds the second half-cycle back down
            WAVE_TRI: sample_o = phase_i[M-1] ? ~{phase_i[M-2:0], 1'b0}
                                              :  {phase_i[M-2:0], 1'b0};
            default:  sample_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dds_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dds_voice_bank : NV time-multiplexed DDS voices summed into one mix   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter int NV = 4,
    parameter int N  = 16,
    parameter int M  = 12,
    parameter int VW = clog2(NV),
    parameter int MW = M + VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run_i,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [VW-1:0] cfg_addr_i,
    input  logic [N-1:0]  cfg_tw_i,
    input  logic [1:0]    cfg_wave_i,
    input  logic          cfg_phase_clr_i,
    output logic          cfg_err_o,
    output logic [MW-1:0] mix_out_o,
    output logic          mix_valid_o,
    output logic [VW-1:0] slot_o
);

    localparam logic [VW:0]   NV_W      = (VW+1)'(NV);
    localparam logic [VW-1:0] SLOT_LAST = VW'(NV-1);

    if (!params_ok(NV, N, M)) begin : g_bad_params
        $error("dds_voice_bank: parameter out of range");
    end

    logic [N-1:0]  phase_q [NV];
    logic [N-1:0]  phase_d [NV];
    logic [N-1:0]  tw_q    [NV];
    logic [N-1:0]  tw_d    [NV];
    wave_e         wave_q  [NV];
    wave_e         wave_d  [NV];

    logic [VW-1:0] slot_q, slot_d;
    logic [M-1:0]  sample_q, sample_d;
    logic          last_q, last_d;
    logic          pvld_q, pvld_d;
    logic [MW-1:0] acc_q, acc_d;
    logic [MW-1:0] mix_q, mix_d;
    logic          mix_valid_q, mix_valid_d;
    logic          cfg_ready_q;
    logic          cfg_err_q, cfg_err_d;

    logic          wr_w;
    logic          addr_ok_w;
    logic          last_w;
    logic [M-1:0]  shaped_w;

    assign wr_w      = cfg_valid_i & cfg_ready_q;
    assign addr_ok_w = ({1'b0, cfg_addr_i} < NV_W);
    assign last_w    = (slot_q == SLOT_LAST);

    dds_wave_shaper #(.M(M)) u_shaper (
        .wave_i   (wave_q[slot_q]),
        .phase_i  (phase_q[slot_q][N-1 -: M]),
        .sample_o (shaped_w)
    );

    // Config writes are applied after the slot increment so a colliding write wins
    always_comb begin
        for (int v = 0; v < NV; v++) begin
            phase_d[v] = phase_q[v];
            tw_d[v]    = tw_q[v];
            wave_d[v]  = wave_q[v];
        end
        cfg_err_d = cfg_err_q;
        if (run_i) begin
            phase_d[slot_q] = phase_q[slot_q] + tw_q[slot_q];
        end
        if (wr_w) begin
            if (addr_ok_w) begin
                tw_d[cfg_addr_i]   = cfg_tw_i;
                wave_d[cfg_addr_i] = wave_e'(cfg_wave_i);
                if (cfg_phase_clr_i) begin
                    phase_d[cfg_addr_i] = '0;
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        slot_d      = '0;
        sample_d    = sample_q;
        last_d      = 1'b0;
        pvld_d      = run_i;
        acc_d       = acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        if (run_i) begin
            slot_d   = last_w ? '0 : slot_q + 1'b1;
            sample_d = shaped_w;
            last_d   = last_w;
            if (pvld_q) begin
                if (last_q) begin
                    mix_d       = acc_q + MW'(sample_q);
                    acc_d       = '0;
                    mix_valid_d = 1'b1;
                end else begin
                    acc_d = acc_q + MW'(sample_q);
                end
            end
        end else begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                phase_q[v] <= '0;
                tw_q[v]    <= '0;
                wave_q[v]  <= WAVE_MUTE;
            end
            slot_q      <= '0;
            sample_q    <= '0;
            last_q      <= 1'b0;
            pvld_q      <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            for (int v = 0; v < NV; v++) begin
                phase_q[v] <= phase_d[v];
                tw_q[v]    <= tw_d[v];
                wave_q[v]  <= wave_d[v];
            end
            slot_q      <= slot_d;
            sample_q    <= sample_d;
            last_q      <= last_d;
            pvld_q      <= pvld_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign cfg_err_o   = cfg_err_q;
    assign mix_out_o   = mix_q;
    assign mix_valid_o = mix_valid_q;
    assign slot_o      = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dds_voice_bank : directed bench with a frame-level reference model |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dds_voice_bank;

    localparam int NV = 4;
    localparam int N  = 16;
    localparam int M  = 12;
    localparam int VW = 2;
    localparam int MW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [VW-1:0] cfg_addr = '0;
    logic [N-1:0]  cfg_tw = '0;
    logic [1:0]    cfg_wave = '0;
    logic          cfg_phase_clr = 1'b0;
    logic          cfg_err;
    logic [MW-1:0] mix_out;
    logic          mix_valid;
    logic [VW-1:0] slot;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    dds_voice_bank #(.NV(NV), .N(N), .M(M)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run_i           (run),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_addr_i      (cfg_addr),
        .cfg_tw_i        (cfg_tw),
        .cfg_wave_i      (cfg_wave),
        .cfg_phase_clr_i (cfg_phase_clr),
        .cfg_err_o       (cfg_err),
        .mix_out_o       (mix_out),
        .mix_valid_o     (mix_valid),
        .slot_o          (slot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value from the waveform's geometric definition on the 0..4095 range
    function automatic int shape(input int w, input logic [N-1:0] ph);
        int p;
        p = int'(ph) / 16;
        case (w)
            0: return p;
            1: return (p >= 2048) ? 4095 : 0;
            2: return (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
            default: return 0;
        endcase
    endfunction

    logic [N-1:0] m_phase [NV];
    logic [N-1:0] m_tw    [NV];
    int           m_wave  [NV];
    int           pos;
    int           fsum;
    bit           pend;
    int           pend_sum;
    int           exp_mix;
    bit           exp_valid;
    bit           exp_err;
    bit           exp_ready;

    always @(posedge clk or negedge rst_n) begin
        bit accept;
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                m_phase[v] = '0;
                m_tw[v]    = '0;
                m_wave[v]  = 3;
            end
            pos = 0; fsum = 0; pend = 1'b0; pend_sum = 0;
            exp_mix = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_ready = 1'b0;
        end else begin
            accept    = cfg_valid && exp_ready;
            exp_ready = 1'b1;
            exp_valid = 1'b0;
            if (run && pend) begin
                exp_mix   = pend_sum;
                exp_valid = 1'b1;
            end
            pend = 1'b0;
            if (run) begin
                fsum = fsum + shape(m_wave[pos], m_phase[pos]);
                m_phase[pos] = m_phase[pos] + m_tw[pos];
                if (pos == NV - 1) begin
                    pend = 1'b1; pend_sum = fsum; fsum = 0; pos = 0;
                end else begin
                    pos = pos + 1;
                end
            end else begin
                pos = 0; fsum = 0;
            end
            if (accept) begin
                if (int'(cfg_addr) >= NV) begin
                    exp_err = 1'b1;
                end else begin
                    m_tw[cfg_addr]   = cfg_tw;
                    m_wave[cfg_addr] = int'(cfg_wave);
                    if (cfg_phase_clr) m_phase[cfg_addr] = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
            chk("mix_valid", 32'(mix_valid), 32'(exp_valid));
            chk("mix_out",   32'(mix_out),   32'(exp_mix));
            chk("slot",      32'(slot),      32'(pos));
            chk("cfg_err",   32'(cfg_err),   32'(exp_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int tw, input int wave, input bit clr);
        cfg_valid     = 1'b1;
        cfg_addr      = VW'(addr);
        cfg_tw        = N'(tw);
        cfg_wave      = 2'(wave);
        cfg_phase_clr = clr;
        cyc();
        cfg_valid     = 1'b0;
        cfg_phase_clr = 1'b0;
    endtask

    task automatic wait_strobe(output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 4 * NV; i++) begin
            cyc();
            cycles = i + 1;
            if (mix_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_timeout: no mix_valid within %0d cycles at %0t", 4 * NV, $time);
        end
    endtask

    task automatic frames(input int k);
        int c;
        for (int i = 0; i < k; i++) wait_strobe(c);
    endtask

    initial begin
        int c;
        #2 rst_n = 1'b0;
        run = 1'b1;
        checking = 1'b1;
        cyc();
        chk("reset_ready", 32'(cfg_ready), 0);
        chk("reset_mix", 32'(mix_out), 0);
        cyc();
        rst_n = 1'b1;

        // All voices mute after reset
        wait_strobe(c);
        chk("mute_mix_f1", 32'(mix_out), 0);
        wait_strobe(c);
        chk("mute_period", c, NV);
        chk("mute_err", 32'(cfg_err), 0);

        // Voice 0 sawtooth
        run = 1'b0;
        cyc();
        cfg_write(0, 'h1000, 0, 1'b1);
        run = 1'b1;
        wait_strobe(c);
        chk("first_latency", c, NV + 1);
        chk("saw_f1", 32'(mix_out), 'h000);
        frames(1);
        chk("saw_f2", 32'(mix_out), 'h100);
        frames(1);
        chk("saw_f3", 32'(mix_out), 'h200);
        frames(14);
        chk("saw_f17_wrap", 32'(mix_out), 'h000);

        // All voices square at half rate
        run = 1'b0;
        cyc();
        for (int v = 0; v < NV; v++) cfg_write(v, 'h8000, 1, 1'b1);
        run = 1'b1;
        frames(1);
        chk("sqr_f1", 32'(mix_out), 'h0000);
        frames(1);
        chk("sqr_f2", 32'(mix_out), 'h3FFC);
        frames(1);
        chk("sqr_f3", 32'(mix_out), 'h0000);
        cfg_write(2, 'h8000, 1, 1'b1);
        frames(1);
        chk("sqr_clr_f4", 32'(mix_out), 'h2FFD);
        frames(1);
        chk("sqr_clr_f5", 32'(mix_out), 'h0FFF);
        frames(2);

        // Voice 1 triangle alone
        run = 1'b0;
        cyc();
        cfg_write(0, 0, 3, 1'b1);
        cfg_write(2, 0, 3, 1'b1);
        cfg_write(3, 0, 3, 1'b1);
        cfg_write(1, 'h2000, 2, 1'b1);
        run = 1'b1;
        frames(2);
        chk("tri_f2", 32'(mix_out), 'h400);
        frames(1);
        chk("tri_f3_p400", 32'(mix_out), 'h800);
        frames(4);
        chk("tri_f7_pC00", 32'(mix_out), 'h7FF);

        // Write colliding with the slot being updated, phase cleared
        chk("collide_slot", 32'(slot), 1);
        cfg_write(1, 'h2000, 2, 1'b1);
        frames(1);
        chk("collide_f8", 32'(mix_out), 'h3FF);
        frames(1);
        chk("collide_f9", 32'(mix_out), 'h000);
        frames(1);
        chk("collide_f10", 32'(mix_out), 'h400);

        // Write accepted on the strobe edge leaves that mix untouched
        cyc(); cyc(); cyc();
        cfg_write(1, 'h2000, 3, 1'b0);
        chk("wr_strobe_valid", 32'(mix_valid), 1);
        chk("wr_strobe_mix", 32'(mix_out), 'h800);
        frames(1);
        chk("wr_strobe_next", 32'(mix_out), 'h000);

        // Abort a frame by dropping run at slot 2
        cfg_write(0, 'h1000, 0, 1'b0);
        for (int i = 0; i < 2 * NV && pos != 2; i++) cyc();
        chk("abort_slot", 32'(slot), 2);
        run = 1'b0;
        cyc();
        cyc();
        chk("abort_no_strobe", 32'(mix_valid), 0);
        run = 1'b1;
        wait_strobe(c);
        chk("abort_restart_latency", c, NV + 1);
        frames(2);

        // Reset mid-frame
        cyc();
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_mix", 32'(mix_out), 0);
        chk("midrst_slot", 32'(slot), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cfg_write(0, 'h1000, 0, 1'b0);
        run = 1'b1;
        frames(1);
        chk("post_rst_f1", 32'(mix_out), 'h000);
        frames(1);
        chk("post_rst_f2", 32'(mix_out), 'h100);

        cyc();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
